n64_vbus_demux: RTL and testbench

N64_VBUS_DEMUX -- requirements
Module: n64_vbus_demux

---
 rtl/n64_vbus_demux.sv | 122 ++++++++++++
 tb/tb_n64_vbus_demux.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/n64_vbus_demux.sv
// N64 video bus demultiplexer: reassembles S/R/G/B words from the 7-bit muxed bus,
// tracks nDSYNC phase lock, and classifies fields (PAL, interlaced, field parity).
module n64_vbus_demux #(
  parameter int          LOCK_CNT   = 4,
  parameter logic [10:0] PAL_THRESH = 11'd288
) (
  input  logic        VCLK,
  input  logic        nVRST,
  input  logic        nDSYNC_i,
  input  logic [6:0]  D_i,
  output logic [24:0] vdata_o,
  output logic        vdata_valid_o,
  output logic        vlock_o,
  output logic        pal_o,
  output logic        interlaced_o,
  output logic        field_id_o
);

  localparam int             GW       = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0]  LOCK_MAX = GW'(LOCK_CNT);

  logic          r_dsync_n;
  logic [6:0]    r_d;
  logic [1:0]    r_phase;
  logic [3:0]    r_s;
  logic [6:0]    r_r;
  logic [6:0]    r_g;
  logic [2:0]    r_gap;
  logic          r_seen;
  logic [GW-1:0] r_good;
  logic [10:0]   r_lines;
  logic [10:0]   r_last;
  logic          r_first_done;

  logic          w_sync;
  logic [1:0]    w_phase;
  logic          w_emit;
  logic          w_hfall;
  logic          w_vfall;
  logic          w_timeout;
  logic [GW-1:0] w_good_nxt;

  assign w_sync    = ~r_dsync_n;
  assign w_phase   = w_sync ? 2'd0 : ((r_phase == 2'd3) ? 2'd3 : r_phase + 2'd1);
  // Only a phase-2 -> phase-3 step completes a word; saturated phase 3 never re-emits.
  assign w_emit    = r_dsync_n && (r_phase == 2'd2);
  // Edges compare the new S against the S of the last emitted word held in vdata_o.
  assign w_hfall   = w_emit & vdata_o[22] & ~r_s[1];
  assign w_vfall   = w_emit & vdata_o[24] & ~r_s[3];
  assign w_timeout = r_dsync_n && (r_gap == 3'd7);

  always_comb begin
    w_good_nxt = r_good;
    if (w_sync) begin
      // r_gap == 3 means four clocks since the previous nDSYNC low.
      if (r_seen && (r_gap == 3'd3))
        w_good_nxt = (r_good == LOCK_MAX) ? r_good : r_good + GW'(1);
      else
        w_good_nxt = '0;
    end else if (w_timeout) begin
      w_good_nxt = '0;
    end
  end

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      r_dsync_n     <= 1'b1;
      r_d           <= 7'd0;
      r_phase       <= 2'd3;
      r_s           <= 4'd0;
      r_r           <= 7'd0;
      r_g           <= 7'd0;
      r_gap         <= 3'd0;
      r_seen        <= 1'b0;
      r_good        <= '0;
      r_lines       <= 11'd0;
      r_last        <= 11'd0;
      r_first_done  <= 1'b0;
      vdata_o       <= {4'hF, 21'h0};
      vdata_valid_o <= 1'b0;
      vlock_o       <= 1'b0;
      pal_o         <= 1'b0;
      interlaced_o  <= 1'b0;
      field_id_o    <= 1'b0;
    end else begin
      r_dsync_n <= nDSYNC_i;
      r_d       <= D_i;
      r_phase   <= w_phase;

      if (w_phase == 2'd0) r_s <= r_d[3:0];
      if (w_phase == 2'd1) r_r <= r_d;
      if (w_phase == 2'd2) r_g <= r_d;

      vdata_valid_o <= w_emit;
      if (w_emit) vdata_o <= {r_s, r_r, r_g, r_d};

      if (w_sync) begin
        r_gap  <= 3'd0;
        r_seen <= 1'b1;
      end else if (r_gap != 3'd7) begin
        r_gap <= r_gap + 3'd1;
      end
      r_good  <= w_good_nxt;
      vlock_o <= (w_good_nxt == LOCK_MAX);

      // A coincident nHSYNC fall is absorbed by the field reset, not counted.
      if (w_vfall) begin
        r_last       <= r_lines;
        r_lines      <= 11'd0;
        r_first_done <= 1'b1;
        if (vlock_o) begin
          pal_o      <= (r_lines > PAL_THRESH);
          field_id_o <= w_hfall;
          if (r_first_done) interlaced_o <= (r_lines != r_last);
        end
      end else if (w_hfall && (r_lines != 11'h7FF)) begin
        r_lines <= r_lines + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_n64_vbus_demux.sv
// Directed bench for n64_vbus_demux: word assembly, lock tracking, reset, and field classification.
module tb_n64_vbus_demux;

  logic        VCLK;
  logic        nVRST;
  logic        nDSYNC_i;
  logic [6:0]  D_i;
  logic [24:0] vdata_o;
  logic        vdata_valid_o;
  logic        vlock_o;
  logic        pal_o;
  logic        interlaced_o;
  logic        field_id_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  logic [24:0] exp_q[$];
  logic [24:0] last_word;

  n64_vbus_demux dut (
    .VCLK         (VCLK),
    .nVRST        (nVRST),
    .nDSYNC_i     (nDSYNC_i),
    .D_i          (D_i),
    .vdata_o      (vdata_o),
    .vdata_valid_o(vdata_valid_o),
    .vlock_o      (vlock_o),
    .pal_o        (pal_o),
    .interlaced_o (interlaced_o),
    .field_id_o   (field_id_o)
  );

  // clock / reset
  initial VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic drive(input logic sync_n, input logic [6:0] d);
    nDSYNC_i = sync_n;
    D_i      = d;
    @(posedge VCLK);
    #1;
  endtask

  task automatic send_word(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g,
                           input logic [6:0] b);
    exp_q.push_back({s, r, g, b});
    last_word = {s, r, g, b};
    drive(1'b0, {3'b000, s});
    drive(1'b1, r);
    drive(1'b1, g);
    drive(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 7'h00);
  endtask

  function automatic logic [3:0] mk_s(input logic vs, input logic hs);
    return {vs, 1'b1, hs, vs & hs};
  endfunction

  // One field: vsync-fall word (optionally with hsync fall), vsync held, vsync released, n lines.
  task automatic send_field(input int n, input logic same);
    send_word(mk_s(1'b0, ~same), 7'h01, 7'h02, 7'h03);
    send_word(mk_s(1'b0, 1'b1), 7'h04, 7'h05, 7'h06);
    send_word(mk_s(1'b1, 1'b1), 7'h07, 7'h08, 7'h09);
    for (int i = 0; i < n; i++) begin
      send_word(mk_s(1'b1, 1'b0), 7'(i), 7'(i + 1), 7'(i + 2));
      send_word(mk_s(1'b1, 1'b1), 7'(i + 3), 7'h2A, 7'h55);
    end
  endtask

  // scoreboard
  always @(negedge VCLK) begin
    if (nVRST && vdata_valid_o) begin
      n_strobe++;
      if (exp_q.size() == 0) check("unexpected_strobe", {7'h0, vdata_o}, 32'h0);
      else check("vdata_word", {7'h0, vdata_o}, {7'h0, exp_q.pop_front()});
    end
  end

  initial begin
    nVRST    = 1'b0;
    nDSYNC_i = 1'b1;
    D_i      = 7'h00;
    last_word = '0;
    repeat (3) @(posedge VCLK);
    #1;
    check("rst_vdata", {7'h0, vdata_o}, 32'h01E0_0000);
    check("rst_valid", {31'h0, vdata_valid_o}, 32'h0);
    check("rst_vlock", {31'h0, vlock_o}, 32'h0);
    check("rst_pal", {31'h0, pal_o}, 32'h0);
    check("rst_interlaced", {31'h0, interlaced_o}, 32'h0);
    check("rst_field_id", {31'h0, field_id_o}, 32'h0);
    nVRST = 1'b1;
    idle(2);

    // periodic words and lock acquisition
    for (int i = 0; i < 4; i++) send_word(4'hF, 7'h11, 7'h22, 7'h33);
    check("vlock_before_4th_gap", {31'h0, vlock_o}, 32'h0);
    send_word(4'hF, 7'h11, 7'h22, 7'h33);
    check("vlock_after_4th_gap", {31'h0, vlock_o}, 32'h1);
    send_word(4'hF, 7'h11, 7'h22, 7'h33);
    check("strobe_cnt_periodic", n_strobe, 32'd5);

    // truncated word while locked
    drive(1'b0, 7'h0F);
    drive(1'b1, 7'h44);
    check("vlock_hold_before_bad_gap", {31'h0, vlock_o}, 32'h1);
    send_word(4'hE, 7'h12, 7'h23, 7'h34);
    check("vlock_drop_bad_gap", {31'h0, vlock_o}, 32'h0);
    for (int i = 0; i < 3; i++) send_word(4'hF, 7'(8'h40 + i), 7'h5A, 7'h25);
    check("vlock_relock_early", {31'h0, vlock_o}, 32'h0);
    send_word(4'hF, 7'h61, 7'h62, 7'h63);
    check("vlock_relock", {31'h0, vlock_o}, 32'h1);
    check("strobe_cnt_truncated", n_strobe, 32'd10);

    // nDSYNC held high for 10 clocks
    idle(10);
    check("vlock_timeout", {31'h0, vlock_o}, 32'h0);
    check("strobe_cnt_idle", n_strobe, 32'd11);
    check("vdata_hold", {7'h0, vdata_o}, {7'h0, last_word});
    check("valid_low_idle", {31'h0, vdata_valid_o}, 32'h0);

    // reset between R and G captures
    drive(1'b0, 7'h0A);
    drive(1'b1, 7'h55);
    nVRST = 1'b0;
    #1;
    check("rst_mid_vdata", {7'h0, vdata_o}, 32'h01E0_0000);
    check("rst_mid_valid", {31'h0, vdata_valid_o}, 32'h0);
    @(posedge VCLK);
    #1;
    nVRST = 1'b1;
    drive(1'b1, 7'h66);
    drive(1'b1, 7'h77);
    idle(4);
    check("no_strobe_after_rst", n_strobe, 32'd11);
    for (int i = 0; i < 6; i++) send_word(4'hF, 7'(i), 7'h33, 7'(8'h70 + i));
    check("strobe_cnt_new_seq", n_strobe, 32'd16);
    check("vlock_before_fields", {31'h0, vlock_o}, 32'h1);

    // 263-line fields
    send_field(263, 1'b0);
    check("int_first_edge", {31'h0, interlaced_o}, 32'h0);
    send_field(263, 1'b0);
    check("int_263_vs_0", {31'h0, interlaced_o}, 32'h1);
    send_field(263, 1'b0);
    check("int_263_steady", {31'h0, interlaced_o}, 32'h0);
    check("pal_263", {31'h0, pal_o}, 32'h0);

    // 313-line fields
    send_field(313, 1'b0);
    check("pal_after_263", {31'h0, pal_o}, 32'h0);
    send_field(313, 1'b0);
    check("pal_313_first", {31'h0, pal_o}, 32'h1);
    check("int_313_vs_263", {31'h0, interlaced_o}, 32'h1);
    send_field(262, 1'b1);
    check("pal_313", {31'h0, pal_o}, 32'h1);
    check("int_313_steady", {31'h0, interlaced_o}, 32'h0);
    check("fid_odd_a", {31'h0, field_id_o}, 32'h1);

    // alternating 262/263
    send_field(263, 1'b0);
    check("int_alt_a", {31'h0, interlaced_o}, 32'h1);
    check("fid_even_a", {31'h0, field_id_o}, 32'h0);
    check("pal_262", {31'h0, pal_o}, 32'h0);
    send_field(262, 1'b1);
    check("int_alt_b", {31'h0, interlaced_o}, 32'h1);
    check("fid_odd_b", {31'h0, field_id_o}, 32'h1);
    send_field(263, 1'b0);
    check("int_alt_c", {31'h0, interlaced_o}, 32'h1);
    check("fid_even_b", {31'h0, field_id_o}, 32'h0);
    send_word(mk_s(1'b0, 1'b1), 7'h10, 7'h20, 7'h30);
    send_word(4'hF, 7'h11, 7'h21, 7'h31);
    check("int_alt_close", {31'h0, interlaced_o}, 32'h1);

    // field flags hold while unlocked
    idle(10);
    check("vlock_lost_fields", {31'h0, vlock_o}, 32'h0);
    send_word(mk_s(1'b0, 1'b0), 7'h13, 7'h23, 7'h33);
    send_word(4'hF, 7'h14, 7'h24, 7'h34);
    check("fid_hold_unlocked", {31'h0, field_id_o}, 32'h0);
    check("int_hold_unlocked", {31'h0, interlaced_o}, 32'h1);
    idle(4);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
